// File: rtl/vga_timing_pkg.sv
// Timing constants and helpers shared by the 1280x1024@60 sync generator.
// Counter width is fixed at 11 bits, so totals up to 2048 fit.
package vga_timing_pkg;

    localparam int CNT_W = 11;

    localparam int   DEF_HPIXELS  = 1688;
    localparam int   DEF_HVISIBLE = 1280;
    localparam int   DEF_HFP      = 48;
    localparam int   DEF_HSW      = 112;
    localparam int   DEF_VLINES   = 1066;
    localparam int   DEF_VVISIBLE = 1024;
    localparam int   DEF_VFP      = 1;
    localparam int   DEF_VSW      = 3;
    localparam logic DEF_HPOL     = 1'b1;
    localparam logic DEF_VPOL     = 1'b1;

    // Bounds carry one extra bit so an upper bound of 2048 stays representable.
    typedef struct packed {
        logic [CNT_W:0] lo;
        logic [CNT_W:0] hi;
    } sync_win_t;

    function automatic sync_win_t sync_window(input int visible, input int porch, input int width);
        sync_win_t w;
        w.lo = (CNT_W + 1)'(visible + porch);
        w.hi = (CNT_W + 1)'(visible + porch + width);
        return w;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the raster: wrap counter plus registered sync decode and a
// next-state visible-window decode for the top to combine across axes.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   TOTAL   = DEF_HPIXELS,
    parameter int   VISIBLE = DEF_HVISIBLE,
    parameter int   PORCH   = DEF_HFP,
    parameter int   SYNC_W  = DEF_HSW,
    parameter logic POL     = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             active_nxt_o,
    output logic             sync_o
);

    localparam sync_win_t        WIN     = sync_window(VISIBLE, PORCH, SYNC_W);
    localparam logic [CNT_W:0]   SYNC_LO = WIN.lo;
    localparam logic [CNT_W:0]   SYNC_HI = WIN.hi;
    localparam logic [CNT_W:0]   VIS     = (CNT_W + 1)'(VISIBLE);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_q, sync_d;
    logic             in_sync;

    assign wrap_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Decode from the next count so flags line up with the count they describe.
    assign in_sync      = ({1'b0, cnt_d} >= SYNC_LO) && ({1'b0, cnt_d} < SYNC_HI);
    assign sync_d       = in_sync ? POL : ~POL;
    assign active_nxt_o = ({1'b0, cnt_d} < VIS);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= LAST;
            sync_q <= ~POL;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign sync_o = sync_q;

endmodule

// File: rtl/vga_timing_1280x1024.sv
// Raster timing generator: counters, syncs, video-on and start strobes,
// all registered so every output describes the same (hc, vc) pixel.
module vga_timing_1280x1024
    import vga_timing_pkg::*;
#(
    parameter int   HPIXELS  = DEF_HPIXELS,
    parameter int   HVISIBLE = DEF_HVISIBLE,
    parameter int   HFP      = DEF_HFP,
    parameter int   HSW      = DEF_HSW,
    parameter int   VLINES   = DEF_VLINES,
    parameter int   VVISIBLE = DEF_VVISIBLE,
    parameter int   VFP      = DEF_VFP,
    parameter int   VSW      = DEF_VSW,
    parameter logic HPOL     = DEF_HPOL,
    parameter logic VPOL     = DEF_VPOL
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ce,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             hsync,
    output logic             vsync,
    output logic             vidon,
    output logic             line_start,
    output logic             frame_start
);

    logic h_wrap, v_wrap;
    logic h_act_nxt, v_act_nxt;
    logic v_inc;

    logic vidon_q, vidon_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    assign v_inc = ce & h_wrap;

    vga_axis_counter #(
        .TOTAL   (HPIXELS),
        .VISIBLE (HVISIBLE),
        .PORCH   (HFP),
        .SYNC_W  (HSW),
        .POL     (HPOL)
    ) u_h (
        .clk_i        (clk),
        .rst_i        (clr),
        .inc_i        (ce),
        .cnt_o        (hc),
        .wrap_o       (h_wrap),
        .active_nxt_o (h_act_nxt),
        .sync_o       (hsync)
    );

    vga_axis_counter #(
        .TOTAL   (VLINES),
        .VISIBLE (VVISIBLE),
        .PORCH   (VFP),
        .SYNC_W  (VSW),
        .POL     (VPOL)
    ) u_v (
        .clk_i        (clk),
        .rst_i        (clr),
        .inc_i        (v_inc),
        .cnt_o        (vc),
        .wrap_o       (v_wrap),
        .active_nxt_o (v_act_nxt),
        .sync_o       (vsync)
    );

    // With ce=1 the next count is zero exactly when the current one wraps.
    always_comb begin
        vidon_d       = h_act_nxt & v_act_nxt;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (ce) begin
            line_start_d  = h_wrap;
            frame_start_d = h_wrap & v_wrap;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vidon_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vidon_q       <= vidon_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vidon       = vidon_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_1280x1024.sv
// Bench for the raster timing generator: full-size instance plus a reduced
// instance so whole-frame properties fit in a short run.
module tb_vga_timing_1280x1024;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        vid;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic ce  = 1'b1;

    logic [10:0] hc, vc, hc_s, vc_s;
    logic hsync, vsync, vidon, line_start, frame_start;
    logic hsync_s, vsync_s, vidon_s, line_start_s, frame_start_s;

    int checks = 0;
    int errors = 0;
    longint p = 0;

    always #5 clk = ~clk;

    vga_timing_1280x1024 dut (
        .clk(clk), .clr(clr), .ce(ce), .hc(hc), .vc(vc),
        .hsync(hsync), .vsync(vsync), .vidon(vidon),
        .line_start(line_start), .frame_start(frame_start)
    );

    vga_timing_1280x1024 #(
        .HPIXELS(20), .HVISIBLE(12), .HFP(2), .HSW(3),
        .VLINES(9), .VVISIBLE(5), .VFP(1), .VSW(2),
        .HPOL(1'b1), .VPOL(1'b1)
    ) dut_s (
        .clk(clk), .clr(clr), .ce(ce), .hc(hc_s), .vc(vc_s),
        .hsync(hsync_s), .vsync(vsync_s), .vidon(vidon_s),
        .line_start(line_start_s), .frame_start(frame_start_s)
    );

    // Position model: p counts enabled edges since reset; p=0 is the last pixel of a frame.
    function automatic obs_t model_at(longint pp, int H, int HV, int HF, int HS,
                                      int V, int VV, int VF, int VS);
        obs_t o;
        int h, v;
        longint k;
        if (pp == 0) begin
            h = H - 1;
            v = V - 1;
        end else begin
            k = (pp - 1) % (H * V);
            h = int'(k % H);
            v = int'(k / H);
        end
        o.hc  = 11'(h);
        o.vc  = 11'(v);
        o.hs  = (h >= HV + HF) && (h < HV + HF + HS);
        o.vs  = (v >= VV + VF) && (v < VV + VF + VS);
        o.vid = (h < HV) && (v < VV);
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(posedge clk or posedge clr) begin
        if (clr) p = 0;
        else if (ce) p = p + 1;
    end

    always @(negedge clk) begin
        obs_t gb, gs, eb, es;
        gb = '{hc, vc, hsync, vsync, vidon, line_start, frame_start};
        gs = '{hc_s, vc_s, hsync_s, vsync_s, vidon_s, line_start_s, frame_start_s};
        eb = model_at(p, 1688, 1280, 48, 112, 1066, 1024, 1, 3);
        es = model_at(p, 20, 12, 2, 3, 9, 5, 1, 2);
        chk("big_cycle", 32'(gb), 32'(eb));
        chk("small_cycle", 32'(gs), 32'(es));
    end

    initial begin
        int nvid, nhs, hs_first, hs_last, vid1280, found;
        int svid, svs, sfs, fs_pos0, fs_pos1;

        ce  = 1'b1;
        clr = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_hc", 32'(hc), 32'd1687);
        chk("reset_vc", 32'(vc), 32'd1065);
        chk("reset_flags", {27'd0, hsync, vsync, vidon, line_start, frame_start}, 32'd0);
        clr = 1'b0;
        @(negedge clk);
        chk("first_hc", 32'(hc), 32'd0);
        chk("first_vc", 32'(vc), 32'd0);
        chk("first_flags", {27'd0, hsync, vsync, vidon, line_start, frame_start}, 32'b00111);

        nvid = 0; nhs = 0; hs_first = -1; hs_last = -1; vid1280 = -1;
        for (int i = 0; i < 1688; i++) begin
            if (vidon) nvid++;
            if (hsync) begin
                nhs++;
                if (hs_first < 0) hs_first = int'(hc);
                hs_last = int'(hc);
            end
            if (hc == 11'd1280) vid1280 = int'(vidon);
            @(negedge clk);
        end
        chk("line_vidon_count", 32'(nvid), 32'd1280);
        chk("vidon_at_1280", 32'(vid1280), 32'd0);
        chk("hsync_count", 32'(nhs), 32'd112);
        chk("hsync_first", 32'(hs_first), 32'd1328);
        chk("hsync_last", 32'(hs_last), 32'd1439);
        chk("line2_hc", 32'(hc), 32'd0);
        chk("line2_vc", 32'(vc), 32'd1);
        chk("line2_starts", {30'd0, line_start, frame_start}, 32'b10);

        for (int i = 0; i < 3000; i++) begin
            ce = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        ce = 1'b1;

        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            if (hc == 11'd1400) found = 1;
            else @(negedge clk);
        end
        chk("reach_hc1400", 32'(found), 32'd1);
        chk("hsync_at_1400", 32'(hsync), 32'd1);
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        chk("async_hsync", 32'(hsync), 32'd0);
        chk("async_hc", 32'(hc), 32'd1687);
        chk("async_vc", 32'(vc), 32'd1065);
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("restart_pos", {10'd0, hc, vc}, 32'd0);
        chk("restart_flags", {27'd0, hsync, vsync, vidon, line_start, frame_start}, 32'b00111);

        // Two whole frames of the reduced instance: 20*9 = 180 clocks each.
        svid = 0; svs = 0; sfs = 0; fs_pos0 = -1; fs_pos1 = -1;
        for (int i = 0; i < 360; i++) begin
            if (vidon_s) svid++;
            if (vsync_s) svs++;
            if (frame_start_s) begin
                sfs++;
                if (fs_pos0 < 0) fs_pos0 = i;
                else fs_pos1 = i;
            end
            @(negedge clk);
        end
        chk("small_vidon_2frames", 32'(svid), 32'd120);
        chk("small_vsync_2frames", 32'(svs), 32'd80);
        chk("small_fs_count", 32'(sfs), 32'd2);
        chk("small_fs_period", 32'(fs_pos1 - fs_pos0), 32'd180);

        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            if (hc_s == 11'd19 && vc_s == 11'd8) found = 1;
            else @(negedge clk);
        end
        chk("reach_corner", 32'(found), 32'd1);
        @(negedge clk);
        chk("corner_pos", {10'd0, hc_s, vc_s}, 32'd0);
        chk("corner_flags", {27'd0, hsync_s, vsync_s, vidon_s, line_start_s, frame_start_s}, 32'b00111);
        @(negedge clk);
        chk("corner_fs_single", 32'(frame_start_s), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
